audio_dac_sequencer: RTL and testbench

AUDIO_DAC_SEQUENCER -- requirements
Module: audio_dac_sequencer

---
 rtl/audio_dac_sequencer.sv | 104 ++++++++++
 tb/tb_audio_dac_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_sequencer.sv
// audio_dac_sequencer: FIFO-fed stereo sample sequencer for a hybrid PWM/SD DAC.
// Define AUDIO_SEQ_RAMP_EN to slew outputs toward midpoint when idle, draining or starved.
module audio_dac_sequencer #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           in_l,
   input  logic [15:0]           in_r,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [15:0]           period,
   input  logic                  enable,
   input  logic                  shutdown,
   output logic [15:0]           d_l,
   output logic [15:0]           d_r,
   output logic                  terminate,
   output logic                  sample_tick,
   output logic [DEPTH_LOG2:0]   level,
   output logic [7:0]            underruns,
   output logic [2:0]            state
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW = DEPTH_LOG2 + 1;
   localparam logic [15:0] MID = 16'h8000;
   typedef enum logic [2:0] {IDLE = 3'd0, PRIME = 3'd1, RUN = 3'd2, DRAIN = 3'd3, SHUTDOWN = 3'd4} state_t;
   state_t st, st_n;
   logic [31:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   logic [15:0] cnt, per_q;
   logic rdy_en, wr, pop, empty, underrun, wrap;
   assign state = st;
   assign terminate = st == SHUTDOWN;
   assign empty = level == '0;
   assign in_ready = rdy_en && !level[DEPTH_LOG2] && st != SHUTDOWN;
   assign wr = in_valid && in_ready;
   assign pop = sample_tick && !empty && (st == RUN || st == DRAIN);
   assign underrun = sample_tick && empty && st == RUN;
   assign wrap = cnt == per_q;
   always_comb begin
      st_n = (shutdown || st == SHUTDOWN) ? SHUTDOWN :
             st == IDLE  ? (enable ? PRIME : IDLE) :
             st == PRIME ? (!enable ? IDLE : level[DEPTH_LOG2:DEPTH_LOG2-1] != 2'b00 ? RUN : PRIME) :
             st == RUN   ? (enable ? RUN : DRAIN) :
             st == DRAIN ? (enable ? RUN : (sample_tick && empty) ? IDLE : DRAIN) : IDLE;
   end
   // period is latched only at a wrap so a change never truncates the current interval
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= IDLE;
         rdy_en <= 1'b0;
         cnt <= '0;
         per_q <= '0;
         sample_tick <= 1'b0;
         wptr <= '0;
         rptr <= '0;
         level <= '0;
         underruns <= '0;
      end else begin
         st <= st_n;
         rdy_en <= 1'b1;
         sample_tick <= wrap;
         cnt <= wrap ? '0 : cnt + 16'd1;
         if (wrap) per_q <= period;
         if (underrun && underruns != 8'hFF) underruns <= underruns + 8'd1;
         if (st_n == SHUTDOWN) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
         end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level <= level + LW'(wr) - LW'(pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= {in_l, in_r};
   end
`ifdef AUDIO_SEQ_RAMP_EN
   logic ramp;
   assign ramp = sample_tick && (st == IDLE || underrun || (st == DRAIN && empty));
   function automatic logic [15:0] slew(input logic [15:0] x);
      return x > 16'h8100 ? x - 16'h0100 : x < 16'h7F00 ? x + 16'h0100 : MID;
   endfunction
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_l <= MID;
         d_r <= MID;
      end else if (pop) begin
         {d_l, d_r} <= mem[rptr];
`ifdef AUDIO_SEQ_RAMP_EN
      end else if (ramp) begin
         d_l <= slew(d_l);
         d_r <= slew(d_r);
`else
      end else if (st_n == IDLE) begin
         d_l <= MID;
         d_r <= MID;
`endif
      end
   end
endmodule

// File: tb/tb_audio_dac_sequencer.sv
// tb_audio_dac_sequencer: scenario tasks plus randomized traffic against a queue-based model.
module tb_audio_dac_sequencer;
   logic clk = 0, reset = 1;
   logic [15:0] in_l = 0, in_r = 0, period = 0;
   logic in_valid = 0, enable = 0, shutdown = 0;
   logic in_ready, terminate, sample_tick;
   logic [15:0] d_l, d_r;
   logic [4:0] level;
   logic [7:0] underruns;
   logic [2:0] state;
   int total = 0, bad = 0;
   logic [31:0] q[$];
   int m_state, m_cnt;
   logic [15:0] m_per, m_dl, m_dr;
   logic [7:0] m_und;
   bit m_tick, m_rdy;

   audio_dac_sequencer #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .reset(reset), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
      .in_ready(in_ready), .period(period), .enable(enable), .shutdown(shutdown),
      .d_l(d_l), .d_r(d_r), .terminate(terminate), .sample_tick(sample_tick),
      .level(level), .underruns(underruns), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

`ifdef AUDIO_SEQ_RAMP_EN
   function automatic logic [15:0] toward(input logic [15:0] x);
      int v;
      v = int'(x);
      if (v > 32768 + 256) return 16'(v - 256);
      if (v < 32768 - 256) return 16'(v + 256);
      return 16'h8000;
   endfunction
`endif

   function automatic bit m_ready();
      return m_rdy && q.size() < 16 && m_state != 4;
   endfunction

   task automatic step();
      int sz = q.size();
      int ns;
      bit wr, pop, und;
      wr = in_valid && m_ready();
      pop = m_tick && sz > 0 && (m_state == 2 || m_state == 3);
      und = m_tick && sz == 0 && m_state == 2;
      ns = (shutdown || m_state == 4) ? 4 :
           m_state == 0 ? (enable ? 1 : 0) :
           m_state == 1 ? (!enable ? 0 : sz >= 8 ? 2 : 1) :
           m_state == 2 ? (enable ? 2 : 3) :
           (enable ? 2 : (m_tick && sz == 0) ? 0 : 3);
      if (pop) {m_dl, m_dr} = q.pop_front();
`ifdef AUDIO_SEQ_RAMP_EN
      else if (m_tick && (m_state == 0 || und || (m_state == 3 && sz == 0))) begin
         m_dl = toward(m_dl);
         m_dr = toward(m_dr);
      end
`else
      else if (ns == 0) begin
         m_dl = 16'h8000;
         m_dr = 16'h8000;
      end
`endif
      if (ns == 4) q.delete();
      else if (wr) q.push_back({in_l, in_r});
      if (und && m_und != 8'hFF) m_und++;
      if (m_cnt == int'(m_per)) begin
         m_cnt = 0;
         m_tick = 1;
         m_per = period;
      end else begin
         m_cnt++;
         m_tick = 0;
      end
      m_state = ns;
      m_rdy = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      in_valid = 0;
      enable = 0;
      shutdown = 0;
      #1;
      q.delete();
      m_state = 0; m_cnt = 0; m_per = 0; m_tick = 0;
      m_dl = 16'h8000; m_dr = 16'h8000; m_und = 0; m_rdy = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
   endtask

   task automatic push_n(input int n, input logic [15:0] bl, input logic [15:0] br);
      int i = 0;
      for (int c = 0; c < 4 * n + 20 && i < n; c++) begin
         in_valid = 1;
         in_l = bl + 16'(i);
         in_r = br + 16'(i);
         if (m_ready()) i++;
         step();
      end
      in_valid = 0;
      total++;
      if (i != n) begin bad++; $display("FAIL push_n accepted=%0d want=%0d", i, n); end
   endtask

   task automatic test_reset();
      period = 3;
      do_reset();
      total++;
      if ({state, level, d_l, d_r, terminate, sample_tick, underruns, in_ready} !==
          {3'd0, 5'd0, 16'h8000, 16'h8000, 1'b0, 1'b0, 8'd0, 1'b0}) begin
         bad++;
         $display("FAIL reset_values got st=%0d lvl=%0d dl=%h dr=%h term=%b tick=%b und=%0d rdy=%b", state, level, d_l, d_r, terminate, sample_tick, underruns, in_ready);
      end
      step();
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b want=1", in_ready); end
   endtask

   task automatic test_playback();
      int k = 0, last = -1, cyc = 0;
      period = 3;
      do_reset();
      enable = 1;
      push_n(8, 16'h1000, 16'h2000);
      for (int c = 0; c < 20 && state !== 3'd2; c++) step();
      total++;
      if (state !== 3'd2 || level !== 5'd8) begin bad++; $display("FAIL prime_to_run got st=%0d lvl=%0d want st=2 lvl=8", state, level); end
      while (k < 8 && cyc < 60) begin
         if (sample_tick === 1'b1) begin
            if (last >= 0) begin
               total++;
               if (cyc - last != 4) begin bad++; $display("FAIL tick_gap got=%0d want=4", cyc - last); end
            end
            last = cyc;
            step();
            cyc++;
            total++;
            if ({d_l, d_r} !== {16'h1000 + 16'(k), 16'h2000 + 16'(k)}) begin
               bad++;
               $display("FAIL pop_data k=%0d got=%h/%h want=%h/%h", k, d_l, d_r, 16'h1000 + 16'(k), 16'h2000 + 16'(k));
            end
            k++;
         end else begin
            step();
            cyc++;
         end
      end
      total++;
      if (k != 8) begin bad++; $display("FAIL playback_pops got=%0d want=8", k); end
   endtask

   task automatic test_full();
      bit found = 0;
      period = 7;
      do_reset();
      push_n(16, 16'h4000, 16'h5000);
      total++;
      if (level !== 5'd16 || in_ready !== 1'b0) begin bad++; $display("FAIL full got lvl=%0d rdy=%b want 16/0", level, in_ready); end
      in_valid = 1;
      in_l = 16'hDEAD;
      in_r = 16'hBEEF;
      repeat (3) step();
      total++;
      if (level !== 5'd16) begin bad++; $display("FAIL no_17th got lvl=%0d want=16", level); end
      enable = 1;
      for (int c = 0; c < 40 && !found; c++) begin
         if (state === 3'd2 && sample_tick === 1'b1) found = 1;
         else step();
      end
      total++;
      if (!found || in_ready !== 1'b0) begin bad++; $display("FAIL run_tick_full found=%b rdy=%b want 1/0", found, in_ready); end
      step();
      total++;
      if (level !== 5'd15 || d_l !== 16'h4000) begin bad++; $display("FAIL pop_while_full got lvl=%0d dl=%h want 15/4000", level, d_l); end
      step();
      total++;
      if (level !== 5'd16) begin bad++; $display("FAIL refill got lvl=%0d want=16", level); end
      in_valid = 0;
      reset = 1;
      #1;
      total++;
      if ({state, level, d_l, d_r} !== {3'd0, 5'd0, 16'h8000, 16'h8000}) begin
         bad++;
         $display("FAIL async_reset_run got st=%0d lvl=%0d dl=%h dr=%h", state, level, d_l, d_r);
      end
      do_reset();
   endtask

   task automatic test_underrun();
      period = 0;
      do_reset();
      enable = 1;
      push_n(8, 16'h0FF9, 16'hEFF9);
      for (int c = 0; c < 40 && !(state === 3'd2 && level === 5'd0); c++) step();
      repeat (300) step();
      total++;
      if (underruns !== 8'd255 || state !== 3'd2) begin bad++; $display("FAIL underrun_sat got und=%0d st=%0d want 255/2", underruns, state); end
      repeat (20) step();
      total++;
      if (underruns !== 8'd255) begin bad++; $display("FAIL underrun_hold got=%0d want=255", underruns); end
      total++;
`ifdef AUDIO_SEQ_RAMP_EN
      if ({d_l, d_r} !== 32'h80008000) begin bad++; $display("FAIL underrun_data got=%h/%h want=8000/8000", d_l, d_r); end
`else
      if ({d_l, d_r} !== 32'h1000F000) begin bad++; $display("FAIL underrun_data got=%h/%h want=1000/f000", d_l, d_r); end
`endif
   endtask

   task automatic test_drain();
      int pops = 0, prev = 5, cyc = 0;
      logic [7:0] u0;
      period = 3;
      do_reset();
      enable = 1;
      push_n(8, 16'h3000, 16'h6000);
      for (int c = 0; c < 80 && !(state === 3'd2 && level === 5'd5); c++) step();
      total++;
      if (state !== 3'd2 || level !== 5'd5) begin bad++; $display("FAIL drain_setup got st=%0d lvl=%0d want 2/5", state, level); end
      enable = 0;
      u0 = m_und;
      step();
      total++;
      if (state !== 3'd3) begin bad++; $display("FAIL drain_enter got st=%0d want=3", state); end
      if (int'(level) < prev) pops += prev - int'(level);
      prev = int'(level);
      while (state !== 3'd0 && cyc < 60) begin
         step();
         cyc++;
         if (int'(level) < prev) pops += prev - int'(level);
         prev = int'(level);
      end
      total++;
      if (pops != 5 || state !== 3'd0 || underruns !== u0) begin
         bad++;
         $display("FAIL drain_done got pops=%0d st=%0d und=%0d want 5/0/%0d", pops, state, underruns, u0);
      end
      total++;
      if ({d_l, d_r} !== {m_dl, m_dr}) begin bad++; $display("FAIL drain_data got=%h/%h want=%h/%h", d_l, d_r, m_dl, m_dr); end
   endtask

   task automatic test_shutdown();
      logic [31:0] hd;
      period = 1;
      do_reset();
      enable = 1;
      push_n(8, 16'h7000, 16'h9000);
      for (int c = 0; c < 60 && !(state === 3'd2 && level <= 5'd6); c++) step();
      shutdown = 1;
      in_valid = 1;
      in_l = 16'h1234;
      in_r = 16'h5678;
      step();
      shutdown = 0;
      total++;
      if ({state, terminate, level, in_ready} !== {3'd4, 1'b1, 5'd0, 1'b0}) begin
         bad++;
         $display("FAIL shutdown_enter got st=%0d term=%b lvl=%0d rdy=%b want 4/1/0/0", state, terminate, level, in_ready);
      end
      hd = {m_dl, m_dr};
      total++;
      if ({d_l, d_r} !== hd) begin bad++; $display("FAIL shutdown_data got=%h/%h want=%h", d_l, d_r, hd); end
      enable = 0;
      repeat (5) step();
      total++;
      if ({state, level, d_l, d_r} !== {3'd4, 5'd0, hd}) begin
         bad++;
         $display("FAIL shutdown_hold got st=%0d lvl=%0d d=%h/%h want 4/0/%h", state, level, d_l, d_r, hd);
      end
      in_valid = 0;
      reset = 1;
      #1;
      total++;
      if ({state, d_l, terminate, level} !== {3'd0, 16'h8000, 1'b0, 5'd0}) begin
         bad++;
         $display("FAIL shutdown_reset got st=%0d dl=%h term=%b lvl=%0d", state, d_l, terminate, level);
      end
      do_reset();
   endtask

   task automatic test_random();
      bit exp_rdy;
      period = 16'($urandom_range(0, 3));
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_l = 16'($urandom);
         in_r = 16'($urandom);
         if ($urandom_range(0, 60) == 0) enable = !enable;
         if ($urandom_range(0, 200) == 0) period = 16'($urandom_range(0, 5));
         exp_rdy = m_ready();
         total++;
         if (in_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, in_ready, exp_rdy); end
         step();
         total++;
         if ({state, level, d_l, d_r, sample_tick, underruns, terminate} !==
             {3'(m_state), 5'(q.size()), m_dl, m_dr, m_tick, m_und, m_state == 4}) begin
            bad++;
            $display("FAIL rand_out c=%0d got st=%0d lvl=%0d d=%h/%h tk=%b und=%0d want st=%0d lvl=%0d d=%h/%h tk=%b und=%0d",
                     c, state, level, d_l, d_r, sample_tick, underruns, m_state, q.size(), m_dl, m_dr, m_tick, m_und);
         end
      end
   endtask

   initial begin
      test_reset();
      test_playback();
      test_full();
      test_underrun();
      test_drain();
      test_shutdown();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
